// File: rtl/shift_out_register.sv
// Parallel-in, serial-out shift register with frame strobes (valid/last/done), LSB first.
// Optional build macro SHIFT_OUT_PARITY_EN appends an even-parity bit to every frame.
module shift_out_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SHIFT_OUT_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [FRAME-1:0] shreg, shreg_nxt, load_word;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;

`ifdef SHIFT_OUT_PARITY_EN
    // Parity rides in the top of the shift register so it falls out after the data bits.
    assign load_word = {^din, din};
`else
    assign load_word = din;
`endif

    assign sout       = shreg[0];
    assign sout_valid = (state == SHIFT);
    assign sout_last  = (state == SHIFT) && (cnt == LAST_CNT);
    assign ready      = (state == IDLE) || sout_last;
    assign accept     = load && ready;

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = SHIFT;
            shreg_nxt = load_word;
            cnt_nxt   = '0;
        end else if (state == SHIFT) begin
            // Shifting on the last bit too leaves shreg all zeros once the frame ends.
            shreg_nxt = {1'b0, shreg[FRAME-1:1]};
            if (sout_last) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            done  <= sout_last;
        end
    end

endmodule
